uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver: 8 data bits, no parity, 1 stop bit, LSB first.
- Sits directly upstream of the data memory's UART input path.
- Drives the memory's 8-bit receive byte input and its new-data flag input.
- The memory latches the byte on the rising edge of the flag, so each received frame produces exactly one clean single-cycle pulse.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per bit period (50 MHz / 9600 baud); legal range ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer division), derived localparam used for start-bit mid-point check; not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  8  last correctly framed byte; feeds memory in_uart.
- new_data  output  1  one-cycle pulse when data_out updates; feeds memory uart_new_data.
- frame_err  output  1  one-cycle pulse when stop bit sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; counter=0; bit index=0; shift register=0; data_out=8'h00; new_data=0; frame_err=0; busy=0. Synchronizer flops reset to 1 (line idle). Reset asserted mid-frame aborts the frame with no pulse.
- Input synchronizer: two flops, rx → rx_s; 2-cycle latency. All decisions use rx_s only.
- Counter: width clog2(CLKS_PER_BIT), cleared on every state transition, otherwise increments each cycle.
- IDLE: rx_s==0 → START, counter=0.
- START: at counter==HALF_BIT-1, sample rx_s.
  - 0 → DATA, counter=0, index=0.
  - 1 → glitch; return to IDLE with no pulse.
- DATA: at counter==CLKS_PER_BIT-1, shift[index]=rx_s, counter=0.
  - index==7 → STOP.
  - else index+1.
- STOP: at counter==CLKS_PER_BIT-1, sample rx_s.
  - 1 → data_out=shift, new_data=1 for exactly that next cycle, → IDLE.
  - 0 → frame_err=1 for one cycle, data_out unchanged, → WAIT_HIGH.
- WAIT_HIGH: stays until rx_s==1, then → IDLE. Covers break conditions; no further pulses while rx is held low.
- Pulse timing: new_data and frame_err are registered, never high together, never high for two consecutive cycles.
- Back-to-back frames: new start bit is detected in the first IDLE cycle after STOP; no idle gap is required.
- Sampling: all data and stop samples fall at bit mid-point ±1 cycle. Tolerates ±4% baud mismatch at CLKS_PER_BIT ≥ 16.
- data_out holds its value indefinitely between frames.

Test Plan:
- Reset: CLKS_PER_BIT=16, hold rst_n low 5 cycles → data_out=8'h00, new_data=0, frame_err=0, busy=0. Release; idle line 50 cycles → no pulses.
- Single byte: send 8'hA5 (LSB first, 16 clk/bit) → exactly one new_data pulse, data_out=8'hA5.
  - Pulse occurs 2 (sync) + 8 + 8×16 + 16 cycles ± 1 after the rx falling edge.
  - busy deasserts the same cycle as the pulse.
- Back-to-back: send 8'h00, 8'hFF, 8'h3C with zero idle between frames → three pulses with data_out 00, FF, 3C in order; no frame_err.
- Glitch: rx low for 4 cycles then high → returns to IDLE; no new_data, no frame_err; data_out unchanged.
- Framing error and break: send 8'h55 with stop bit low, then hold rx low 200 cycles → one frame_err pulse, no new_data, data_out keeps its prior value, busy stays high until rx returns high. A following valid 8'h81 → data_out=8'h81 with one new_data pulse.
- Async reset mid-frame: assert rst_n low during data bit 3 of 8'hC3 → outputs reset immediately. Release with rx idle → no pulse. A following valid 8'h12 is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte with new-data/frame-error pulses and busy out.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       new_data;
  logic       frame_err;
  logic       busy;
  modport master (output rx, input data_out, new_data, frame_err, busy);
  modport slave  (input rx, output data_out, new_data, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver producing one clean single-cycle pulse per frame.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave u
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q, data_q;
  logic          new_q, err_q, busy_q, meta_q, rx_s_q;
  logic          bit_end, half_end;
  assign bit_end  = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign half_end = cnt_q == CW'(HALF_BIT - 1);
  assign u.data_out  = data_q;
  assign u.new_data  = new_q;
  assign u.frame_err = err_q;
  assign u.busy      = busy_q;
  // Synchronizer flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      new_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      meta_q  <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      meta_q <= u.rx;
      rx_s_q <= meta_q;
      new_q  <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= cnt_q + 1'b1;
      case (state_q)
        IDLE: if (!rx_s_q) begin
          state_q <= START;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
        START: if (half_end) begin
          state_q <= rx_s_q ? IDLE : DATA;
          busy_q  <= !rx_s_q;
          cnt_q   <= '0;
          idx_q   <= '0;
        end
        DATA: if (bit_end) begin
          shift_q[idx_q] <= rx_s_q;
          idx_q          <= idx_q + 1'b1;
          cnt_q          <= '0;
          if (idx_q == 3'd7) state_q <= STOP;
        end
        STOP: if (bit_end) begin
          cnt_q <= '0;
          if (rx_s_q) begin
            data_q  <= shift_q;
            new_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            err_q   <= 1'b1;
            state_q <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: if (rx_s_q) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a queue of expected pulses with per-cycle output checks.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {bit err; logic [7:0] b; int due;} ev_t;
  ev_t q[$];
  logic [7:0] last_good = 8'h00;
  bit prev_pulse = 1'b0;
  int last_pulse_cyc = 0;
  int fall_cyc = 0;
  uart_rx_if u ();
  uart_rx #(.CLKS_PER_BIT(16)) dut (.clk(clk), .rst_n(rst_n), .u(u));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // Expected pulses: every frame due 2 sync + half bit + 8 data bits + stop bit after the falling edge.
  always @(negedge clk) begin
    bit pulse;
    ev_t e;
    if (!rst_n) begin
      chk("rst_outs", {5'd0, u.data_out, u.new_data, u.frame_err, u.busy}, 16'h0);
      last_good = 8'h00;
      q.delete();
      prev_pulse = 1'b0;
    end else begin
      pulse = u.new_data || u.frame_err;
      if (u.new_data && u.frame_err) chk("both_pulses", 16'd1, 16'd0);
      if (pulse && prev_pulse) chk("pulse_width", 16'd2, 16'd1);
      if (pulse) begin
        if (q.size() == 0) chk("spurious_pulse", {14'd0, u.new_data, u.frame_err}, 16'd0);
        else begin
          e = q.pop_front();
          chk("pulse_kind", {15'd0, u.frame_err}, {15'd0, e.err});
          chk("pulse_time", 16'(cyc >= e.due - 1 && cyc <= e.due + 1), 16'd1);
          last_pulse_cyc = cyc;
          if (u.new_data) begin
            chk("busy_at_pulse", {15'd0, u.busy}, 16'd0);
            if (!e.err) last_good = e.b;
          end
        end
      end else if (q.size() != 0 && cyc > q[0].due + 1) begin
        chk("missing_pulse", 16'd0, 16'd1);
        void'(q.pop_front());
      end
      chk("data_hold", {8'd0, u.data_out}, {8'd0, last_good});
      prev_pulse = pulse;
    end
  end
  task automatic send(input logic [7:0] b, input logic stop);
    u.rx = 1'b0;
    fall_cyc = cyc;
    q.push_back('{err: !stop, b: b, due: cyc + 154});
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      u.rx = b[i];
      repeat (16) @(negedge clk);
    end
    u.rx = stop;
    repeat (16) @(negedge clk);
  endtask
  initial begin
    logic [7:0] c3;
    c3 = 8'hC3;
    u.rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_data", {8'd0, u.data_out}, 16'h0000);
    chk("reset_busy", {15'd0, u.busy}, 16'd0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_busy", {15'd0, u.busy}, 16'd0);
    send(8'hA5, 1'b1);
    chk("a5_data", {8'd0, u.data_out}, 16'h00A5);
    chk("a5_latency", 16'(last_pulse_cyc - fall_cyc >= 153 && last_pulse_cyc - fall_cyc <= 155), 16'd1);
    repeat (20) @(negedge clk);
    send(8'h00, 1'b1);
    chk("b2b_00", {8'd0, u.data_out}, 16'h0000);
    send(8'hFF, 1'b1);
    chk("b2b_ff", {8'd0, u.data_out}, 16'h00FF);
    send(8'h3C, 1'b1);
    chk("b2b_3c", {8'd0, u.data_out}, 16'h003C);
    repeat (20) @(negedge clk);
    u.rx = 1'b0;
    repeat (4) @(negedge clk);
    u.rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_busy", {15'd0, u.busy}, 16'd0);
    chk("glitch_data", {8'd0, u.data_out}, 16'h003C);
    send(8'h55, 1'b0);
    repeat (200) begin
      @(negedge clk);
      chk("break_busy", {15'd0, u.busy}, 16'd1);
    end
    chk("break_data", {8'd0, u.data_out}, 16'h003C);
    u.rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("break_release", {15'd0, u.busy}, 16'd0);
    send(8'h81, 1'b1);
    chk("after_break", {8'd0, u.data_out}, 16'h0081);
    u.rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      u.rx = c3[i];
      repeat (16) @(negedge clk);
    end
    u.rx = c3[3];
    repeat (8) @(negedge clk);
    chk("midframe_busy", {15'd0, u.busy}, 16'd1);
    #1 rst_n = 1'b0;
    #1 chk("async_rst", {5'd0, u.data_out, u.new_data, u.frame_err, u.busy}, 16'h0);
    u.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_rst_data", {8'd0, u.data_out}, 16'h0000);
    send(8'h12, 1'b1);
    chk("post_rst_12", {8'd0, u.data_out}, 16'h0012);
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
